game_event_tracker: RTL and testbench
=====================================

GAME_EVENT_TRACKER -- requirements
Module: game_event_tracker

Interface
REQ-001 SHALL take parameter NUM_CH, default 3: number of collision channels.
REQ-002 SHALL take parameter DAMAGE_MASK, default 3'b001: channels that cost a life.
REQ-003 SHALL take parameter SCORE_MASK, default 3'b010: channels that add score.
REQ-004 SHALL take parameter MAX_LIVES, default 3, with LIVES_W default 2: starting lives and lives-counter width.
REQ-005 SHALL take parameter SCORE_W, default 8: score counter width.
REQ-006 SHALL take parameter INVULN_FRAMES, default 60, with INV_W default 6: post-hit grace period in frames; FLASH_BIT default 2 selects the flash bit.
REQ-007 clk  input  1  system clock; the only clock.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 frame_end  input  1  one-cycle pulse at end of each frame.
REQ-010 start  input  1  level start/restart request; sampled only at frame_end.
REQ-011 collide  input  NUM_CH  level collision flags, any cycle.
REQ-012 lives  output  LIVES_W  remaining lives.
REQ-013 score  output  SCORE_W  saturating score.
REQ-014 state  output  2  00 IDLE, 01 PLAY, 10 INVULN, 11 OVER.
REQ-015 flash  output  1  sprite-blink enable.
REQ-016 event_pulse  output  NUM_CH  one-cycle new-event strobe per channel.

Function
REQ-017 Per channel: sticky bit SHALL set on any cycle collide[i]=1 and clear on the frame_end cycle.
REQ-018 At frame_end, hit_i = sticky_i|collide_i; event_i = hit_i & ~prev_i; prev_i <= hit_i. A collision held across frames SHALL produce exactly one event.
REQ-019 event_pulse SHALL assert for exactly the cycle after frame_end, carrying event_i; all other cycles 0.
REQ-020 Decisions SHALL be taken only on frame_end cycles; lives, score, state, and flash SHALL update in the following cycle.
REQ-021 IDLE: lives=MAX_LIVES, score=0; frame_end with start=1 -> PLAY; events SHALL be ignored.
REQ-022 PLAY: any event on a DAMAGE_MASK channel -> lives-1. If result is 0 -> OVER; else -> INVULN with inv_cnt=INVULN_FRAMES-1.
REQ-023 Multiple damage events in one frame SHALL cost exactly one life.
REQ-024 INVULN: damage events SHALL be ignored. inv_cnt decrements each frame_end. A frame_end with inv_cnt=0 -> PLAY.
REQ-025 PLAY and INVULN: score += popcount(event & SCORE_MASK) per frame_end, saturating at 2^SCORE_W-1 with no wrap.
REQ-026 A channel in both masks SHALL both damage and score.
REQ-027 OVER: lives=0; score frozen; events ignored; frame_end with start=1 -> IDLE, reloading lives and score.
REQ-028 flash SHALL equal inv_cnt[FLASH_BIT] in INVULN and 0 in every other state.
REQ-029 start outside frame_end cycles SHALL have no effect.
REQ-030 The design SHALL be fully synchronous with no combinational path from inputs to outputs.

Reset
REQ-031 reset=1 SHALL force on the next edge: state=IDLE, lives=MAX_LIVES, score=0, flash=0, event_pulse=0, inv_cnt=0, sticky=0, prev=0.
REQ-032 reset SHALL dominate a coincident frame_end, start or collide, including reset mid-INVULN or mid-OVER.

Verification
REQ-033 Reset, then start=1 at frame_end -> state=01, lives=3, score=0.
REQ-034 In PLAY, collide[0] held high 5 frames -> one event_pulse[0], lives 3->2, state=10, flash toggles every 4 frames, state=01 after 60 frame_ends.
REQ-035 In PLAY, collide[1] pulsed once in each of 300 frames -> score saturates at 255, never wraps to 0.
REQ-036 In PLAY, collide[0] and collide[1] high in the same frame -> lives-1 and score+1 in the same update; during INVULN, collide[0] -> lives unchanged.
REQ-037 Third damage event -> lives=0, state=11. Then start at frame_end -> state=00, lives=3, score=0.
REQ-038 reset asserted in the frame_end cycle of a damage event -> lives=3, state=00, event_pulse=0.

Source files
------------

// File: rtl/game_event_tracker.sv
// game_event_tracker: per-frame collision edge detection driving a lives/score/invulnerability game FSM.
module game_event_tracker #(
    parameter int                NUM_CH        = 3,
    parameter logic [NUM_CH-1:0] DAMAGE_MASK   = 3'b001,
    parameter logic [NUM_CH-1:0] SCORE_MASK    = 3'b010,
    parameter int                MAX_LIVES     = 3,
    parameter int                LIVES_W       = 2,
    parameter int                SCORE_W       = 8,
    parameter int                INVULN_FRAMES = 60,
    parameter int                INV_W         = 6,
    parameter int                FLASH_BIT     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_end,
    input  logic               start,
    input  logic [NUM_CH-1:0]  collide,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state,
    output logic               flash,
    output logic [NUM_CH-1:0]  event_pulse
);
    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, INVULN = 2'b10, OVER = 2'b11} st_t;
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);
    localparam logic [INV_W-1:0]   INV_RELOAD = INV_W'(INVULN_FRAMES - 1);
    st_t                st, st_n;
    logic [NUM_CH-1:0]  sticky, prev, hit, evt;
    logic [LIVES_W-1:0] lives_n;
    logic [SCORE_W-1:0] score_n, score_sat;
    logic [INV_W-1:0]   inv_cnt, inv_n;
    logic [SCORE_W:0]   sum;
    logic               dmg;
    assign hit       = sticky | collide;
    assign evt       = hit & ~prev;
    assign dmg       = |(evt & DAMAGE_MASK);
    assign sum       = {1'b0, score} + (SCORE_W+1)'($countones(evt & SCORE_MASK));
    assign score_sat = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    assign state     = st;
    assign flash     = (st == INVULN) & inv_cnt[FLASH_BIT];
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky      <= '0;
            prev        <= '0;
            event_pulse <= '0;
        end else if (frame_end) begin
            sticky      <= '0;
            prev        <= hit;
            event_pulse <= evt;
        end else begin
            sticky      <= hit;
            event_pulse <= '0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= IDLE;
            lives   <= LIVES_INIT;
            score   <= '0;
            inv_cnt <= '0;
        end else begin
            st      <= st_n;
            lives   <= lives_n;
            score   <= score_n;
            inv_cnt <= inv_n;
        end
    end
    always_comb begin
        st_n    = st;
        lives_n = lives;
        score_n = score;
        inv_n   = inv_cnt;
        if (frame_end) begin
            unique case (st)
                IDLE: begin
                    lives_n = LIVES_INIT;
                    score_n = '0;
                    st_n    = start ? PLAY : IDLE;
                end
                PLAY: begin
                    score_n = score_sat;
                    if (dmg) begin
                        lives_n = lives - LIVES_W'(1);
                        st_n    = (lives == LIVES_W'(1)) ? OVER : INVULN;
                        inv_n   = INV_RELOAD;
                    end
                end
                INVULN: begin
                    score_n = score_sat;
                    st_n    = (inv_cnt == '0) ? PLAY : INVULN;
                    inv_n   = (inv_cnt == '0) ? inv_cnt : inv_cnt - INV_W'(1);
                end
                OVER: begin
                    lives_n = start ? LIVES_INIT : '0;
                    score_n = start ? '0 : score;
                    st_n    = start ? IDLE : OVER;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_event_tracker.sv
// tb_game_event_tracker: directed checks of event detection, lives, score saturation, invulnerability and reset.
module tb_game_event_tracker;
    logic       clk = 1'b0;
    logic       reset, frame_end, start;
    logic [2:0] collide;
    logic [1:0] lives;
    logic [7:0] score;
    logic [1:0] state;
    logic       flash;
    logic [2:0] event_pulse;
    int         ntest = 0;
    int         nfail = 0;

    game_event_tracker dut (
        .clk(clk), .reset(reset), .frame_end(frame_end), .start(start), .collide(collide),
        .lives(lives), .score(score), .state(state), .flash(flash), .event_pulse(event_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // inputs change at a negedge; returns at the next negedge with outputs of the intervening edge
    task automatic cyc(input logic fe, input logic st, input logic [2:0] col);
        frame_end = fe;
        start     = st;
        collide   = col;
        @(negedge clk);
    endtask

    task automatic frame(input logic [2:0] col, input logic st);
        cyc(1'b0, 1'b0, col);
        cyc(1'b1, st, col);
    endtask

    initial begin
        reset = 1'b1; frame_end = 1'b0; start = 1'b0; collide = '0;
        @(negedge clk);
        cyc(1'b1, 1'b1, 3'b011);
        cyc(1'b0, 1'b0, 3'b000);
        chk("rst_state", state, 0);
        chk("rst_lives", lives, 3);
        chk("rst_score", score, 0);
        chk("rst_flash", flash, 0);
        chk("rst_evt", event_pulse, 0);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 3'b000);
        chk("start_no_fe", state, 0);
        frame(3'b000, 1'b1);
        chk("play_state", state, 1);
        chk("play_lives", lives, 3);
        chk("play_score", score, 0);

        frame(3'b001, 1'b0);
        chk("hit_evt", event_pulse, 3'b001);
        chk("hit_lives", lives, 2);
        chk("hit_state", state, 2);
        chk("hit_flash", flash, 0);
        cyc(1'b0, 1'b0, 3'b001);
        chk("evt_one_cycle", event_pulse, 0);
        for (int k = 1; k <= 60; k++) begin
            frame((k <= 4) ? 3'b001 : 3'b000, 1'b0);
            chk("inv_evt", event_pulse, 0);
            chk("inv_lives", lives, 2);
            if (k < 60) begin
                chk("inv_state", state, 2);
                chk("inv_flash", flash, ((59 - k) >> 2) & 1);
            end else begin
                chk("inv_end_state", state, 1);
                chk("inv_end_flash", flash, 0);
            end
        end

        frame(3'b011, 1'b0);
        chk("both_evt", event_pulse, 3'b011);
        chk("both_lives", lives, 1);
        chk("both_score", score, 1);
        chk("both_state", state, 2);
        frame(3'b000, 1'b0);
        frame(3'b001, 1'b0);
        chk("inv_dmg_evt", event_pulse, 3'b001);
        chk("inv_dmg_lives", lives, 1);
        chk("inv_dmg_state", state, 2);
        frame(3'b010, 1'b0);
        chk("inv_score", score, 2);
        frame(3'b000, 1'b0);

        for (int n = 1; n <= 300; n++) begin
            frame(3'b010, 1'b0);
            chk("sat_score", score, (2 + n < 255) ? 2 + n : 255);
            frame(3'b000, 1'b0);
        end
        chk("sat_lives", lives, 1);
        chk("sat_state", state, 1);

        frame(3'b001, 1'b0);
        chk("over_lives", lives, 0);
        chk("over_state", state, 3);
        chk("over_score", score, 255);
        chk("over_flash", flash, 0);
        frame(3'b000, 1'b0);
        frame(3'b001, 1'b0);
        chk("over_ignore_lives", lives, 0);
        chk("over_ignore_state", state, 3);
        cyc(1'b0, 1'b1, 3'b000);
        chk("over_start_no_fe", state, 3);
        frame(3'b000, 1'b1);
        chk("restart_state", state, 0);
        chk("restart_lives", lives, 3);
        chk("restart_score", score, 0);

        frame(3'b011, 1'b0);
        chk("idle_evt", event_pulse, 3'b011);
        chk("idle_lives", lives, 3);
        chk("idle_score", score, 0);
        chk("idle_state", state, 0);
        frame(3'b000, 1'b0);

        frame(3'b000, 1'b1);
        chk("play2_state", state, 1);
        frame(3'b000, 1'b0);
        cyc(1'b0, 1'b0, 3'b001);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 3'b001);
        reset = 1'b0;
        chk("rst_dmg_lives", lives, 3);
        chk("rst_dmg_state", state, 0);
        chk("rst_dmg_evt", event_pulse, 0);
        cyc(1'b0, 1'b0, 3'b000);
        chk("rst_dmg_evt2", event_pulse, 0);

        frame(3'b000, 1'b1);
        frame(3'b001, 1'b0);
        chk("play3_hit_state", state, 2);
        for (int k = 0; k < 4; k++) frame(3'b000, 1'b0);
        chk("inv_flash_on", flash, 1);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 3'b011);
        reset = 1'b0;
        chk("rst_inv_state", state, 0);
        chk("rst_inv_flash", flash, 0);
        chk("rst_inv_lives", lives, 3);
        chk("rst_inv_evt", event_pulse, 0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
